// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the divide sequencer: FSM states and iteration count.
package mips_defs;
   localparam int DIV_W     = 32;
   localparam int DIV_ITERS = DIV_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } div_state_e;
endpackage

// File: rtl/div_seq_ctrl_step.sv
// One radix-2 restoring divide iteration, purely combinational.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_rem,
   input  logic              i_msb,
   input  logic [DATA_W-1:0] i_dvs,
   output logic [DATA_W-1:0] o_rem,
   output logic              o_qbit
);
   logic [DATA_W:0]   w_shift;
   logic              w_borrow;
   logic [DATA_W-1:0] w_diff;

   assign w_shift = {i_rem, i_msb};
   // A set shifted-out MSB means the trial is non-negative whatever the low borrow says;
   // the wrapped low difference is then still the exact remainder.
   assign {w_borrow, w_diff} = {1'b0, w_shift[DATA_W-1:0]} - {1'b0, i_dvs};
   assign o_qbit = w_shift[DATA_W] | ~w_borrow;
   assign o_rem  = o_qbit ? w_diff : w_shift[DATA_W-1:0];
endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: freezes F/D/E while running, presents {HI,LO} with a ready strobe.
module div_seq_ctrl
   import mips_defs::*;
#(
   parameter int DATA_W = DIV_ITERS
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_signed_div,
   input  logic [DATA_W-1:0]   i_opa,
   input  logic [DATA_W-1:0]   i_opb,
   input  logic                i_cancel,
   output logic                o_stall,
   output logic                o_flushM,
   output logic                o_div_ready,
   output logic [2*DATA_W-1:0] o_hilores
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   div_state_e          r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rem, r_dvd, r_dvs;
   logic                r_qneg, r_rneg;
   logic [2*DATA_W-1:0] r_result, r_hilores;

   logic                w_accept, w_step, w_last, w_show, w_stall;
   logic [DATA_W-1:0]   w_abs_a, w_abs_b, w_step_rem, w_q, w_q_fix, w_r_fix;
   logic                w_qbit;

   div_step #(.DATA_W(DATA_W)) u_step (
      .i_rem  (r_rem),
      .i_msb  (r_dvd[DATA_W-1]),
      .i_dvs  (r_dvs),
      .o_rem  (w_step_rem),
      .o_qbit (w_qbit)
   );

   assign w_abs_a = (i_signed_div & i_opa[DATA_W-1]) ? -i_opa : i_opa;
   assign w_abs_b = (i_signed_div & i_opb[DATA_W-1]) ? -i_opb : i_opb;
   assign w_q     = {r_dvd[DATA_W-2:0], w_qbit};
   assign w_q_fix = r_qneg ? -w_q : w_q;
   assign w_r_fix = r_rneg ? -w_step_rem : w_step_rem;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      w_show      = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start & ~i_cancel) begin
               w_accept    = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (i_cancel) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_step  = 1'b1;
               w_stall = 1'b1;
               if (r_cnt == LAST) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            // DONE never restarts; a held start is only seen again back in IDLE.
            w_show      = ~i_cancel;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_result  <= '0;
         r_hilores <= '0;
      end else begin
         if (w_accept) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvd  <= w_abs_a;
            r_dvs  <= w_abs_b;
            r_qneg <= i_signed_div & (i_opa[DATA_W-1] ^ i_opb[DATA_W-1]);
            r_rneg <= i_signed_div & i_opa[DATA_W-1];
         end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_step_rem;
            r_dvd <= w_q;
            if (w_last) r_result <= {w_r_fix, w_q_fix};
         end
         if (w_show) r_hilores <= r_result;
      end
   end

   // The finished result is shown during DONE only if not cancelled, so a flush leaves HI/LO untouched.
   assign o_stall     = w_stall;
   assign o_flushM    = w_stall;
   assign o_div_ready = w_show;
   assign o_hilores   = w_show ? r_result : r_hilores;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, stall window, sign cases, cancel and async reset.
module tb_div_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        start, sgn, cancel;
   logic [31:0] opa, opb;
   logic        stall, flushM, rdy;
   logic [63:0] hilores;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   div_seq_ctrl #(.DATA_W(32)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_signed_div (sgn),
      .i_opa        (opa),
      .i_opb        (opb),
      .i_cancel     (cancel),
      .o_stall      (stall),
      .o_flushM     (flushM),
      .o_div_ready  (rdy),
      .o_hilores    (hilores)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Called at a falling edge with the DUT idle; returns one cycle after the ready strobe.
   task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
      int cyc    = 0;
      int nstall = 0;
      bit seen   = 0;
      bit fm_bad = 0;
      start = 1'b1; sgn = s; opa = a; opb = b;
      while (!seen && cyc < 60) begin
         #1;
         if (flushM !== stall) fm_bad = 1;
         if (rdy === 1'b1) seen = 1;
         else begin
            if (stall === 1'b1) nstall++;
            @(negedge clk);
            cyc++;
         end
      end
      check({tag, "_ready_seen"}, 64'(seen), 64'd1);
      check({tag, "_latency"}, 64'(cyc), 64'd33);
      check({tag, "_stall_cycles"}, 64'(nstall), 64'd33);
      check({tag, "_flushM_eq_stall"}, 64'(fm_bad), 64'd0);
      check({tag, "_stall_in_done"}, 64'(stall), 64'd0);
      check({tag, "_hilores"}, hilores, exp);
      start = 1'b0;
      @(negedge clk); #1;
      check({tag, "_ready_one_shot"}, 64'(rdy), 64'd0);
      check({tag, "_hilores_hold"}, hilores, exp);
   endtask

   initial begin
      bit pulsed;
      rst = 1'b1; start = 1'b0; sgn = 1'b0; cancel = 1'b0; opa = '0; opb = '0;
      @(negedge clk); @(negedge clk); #1;
      check("reset_stall", 64'(stall), 64'd0);
      check("reset_flushM", 64'(flushM), 64'd0);
      check("reset_ready", 64'(rdy), 64'd0);
      check("reset_hilores", hilores, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
      run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
      run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
      run_div("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'd16, 64'h0000000F_0FFFFFFF);
      run_div("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_00000001);
      run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);

      // cancel at T+10, restart at T+12
      start = 1'b1; sgn = 1'b0; opa = 32'd1000; opb = 32'd3;
      pulsed = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rdy === 1'b1) pulsed = 1;
         @(negedge clk);
      end
      cancel = 1'b1; start = 1'b0; #1;
      check("cancel_stall", 64'(stall), 64'd0);
      check("cancel_flushM", 64'(flushM), 64'd0);
      if (rdy === 1'b1) pulsed = 1;
      @(negedge clk);
      cancel = 1'b0; #1;
      check("cancel_idle_stall", 64'(stall), 64'd0);
      if (rdy === 1'b1) pulsed = 1;
      check("cancel_no_ready", 64'(pulsed), 64'd0);
      check("cancel_hilores_kept", hilores, 64'h00000005_FFFFFFFF);
      @(negedge clk);
      run_div("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);

      // async reset at T+20 mid-divide
      start = 1'b1; sgn = 1'b0; opa = 32'd1000; opb = 32'd3;
      for (int i = 0; i < 20; i++) @(negedge clk);
      #2;
      rst = 1'b1; start = 1'b0; #1;
      check("arst_stall", 64'(stall), 64'd0);
      check("arst_flushM", 64'(flushM), 64'd0);
      check("arst_ready", 64'(rdy), 64'd0);
      check("arst_hilores", hilores, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
